// File: rtl/adc_scan_scheduler.sv
// Scan controller for the adc_18s022 driver: on each period tick it converts every
// enabled channel in ascending order, keeps the latest result per channel and streams samples out.
module adc_scan_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Scan_en,
  input  logic [7:0]          Chan_mask,
  input  logic [PERIOD_W-1:0] Period,
  output logic                En_convert,
  output logic [2:0]          Adc_channel,
  input  logic                Convert_done,
  input  logic [11:0]         Adc_result,
  output logic                Sample_valid,
  output logic [2:0]          Sample_channel,
  output logic [11:0]         Sample_data,
  output logic                Scan_done,
  input  logic [2:0]          Rd_channel,
  output logic [11:0]         Rd_data,
  output logic                Busy,
  output logic                Overrun,
  output logic                Timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT_DONE, STORE} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic [7:0]          r_scan_mask;
  logic [TO_W-1:0]     r_to_cnt;
  logic [11:0]         r_cap;
  logic [11:0]         r_result [8];
  logic                r_en_convert;
  logic [2:0]          r_chan;
  logic                r_sample_valid;
  logic [2:0]          r_sample_ch;
  logic [11:0]         r_sample_data;
  logic                r_scan_done;
  logic                r_busy;
  logic                r_overrun;
  logic                r_timeout_err;

  logic                w_tick;
  logic                w_more;
  logic [2:0]          w_low_ch;

  // Period of 0 or 1 yields a tick every cycle while scanning is enabled.
  assign w_tick = Scan_en && ((Period == '0) || (r_tick_cnt == Period - 1'b1));
  assign w_more = (r_scan_mask != 8'd0) && Scan_en;

  always_comb begin
    w_low_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_scan_mask[i]) w_low_ch = 3'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || !Scan_en || w_tick) r_tick_cnt <= '0;
    else                           r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state        <= IDLE;
      r_scan_mask    <= 8'd0;
      r_to_cnt       <= '0;
      r_cap          <= 12'd0;
      r_en_convert   <= 1'b0;
      r_chan         <= 3'd0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= 3'd0;
      r_sample_data  <= 12'd0;
      r_scan_done    <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
      for (int i = 0; i < 8; i++) r_result[i] <= 12'd0;
    end else begin
      r_en_convert   <= 1'b0;
      r_sample_valid <= 1'b0;
      r_scan_done    <= 1'b0;
      if (w_tick && r_busy) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_tick && (Chan_mask != 8'd0)) begin
            r_scan_mask <= Chan_mask;
            r_busy      <= 1'b1;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          r_chan       <= w_low_ch;
          r_scan_mask  <= r_scan_mask & (r_scan_mask - 8'd1);
          r_en_convert <= 1'b1;
          r_state      <= START;
        end
        START: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (Convert_done) begin
            r_cap   <= Adc_result;
            r_state <= STORE;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            // Abandon this channel without a sample and carry on with the scan.
            r_timeout_err <= 1'b1;
            if (w_more) begin
              r_state <= SELECT;
            end else begin
              r_scan_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        STORE: begin
          r_result[r_chan] <= r_cap;
          r_sample_valid   <= 1'b1;
          r_sample_ch      <= r_chan;
          r_sample_data    <= r_cap;
          if (w_more) begin
            r_state <= SELECT;
          end else begin
            r_scan_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign En_convert     = r_en_convert;
  assign Adc_channel    = r_chan;
  assign Sample_valid   = r_sample_valid;
  assign Sample_channel = r_sample_ch;
  assign Sample_data    = r_sample_data;
  assign Scan_done      = r_scan_done;
  assign Busy           = r_busy;
  assign Overrun        = r_overrun;
  assign Timeout_err    = r_timeout_err;
  assign Rd_data        = r_result[Rd_channel];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural ADC driver model and a sample scoreboard.
module tb_adc_scan_scheduler;

  localparam int LAT = 20;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Scan_en = 1'b0;
  logic [7:0]  Chan_mask = 8'd0;
  logic [15:0] Period = 16'd0;
  logic        En_convert;
  logic [2:0]  Adc_channel;
  logic        Convert_done = 1'b0;
  logic [11:0] Adc_result = 12'd0;
  logic        Sample_valid;
  logic [2:0]  Sample_channel;
  logic [11:0] Sample_data;
  logic        Scan_done;
  logic [2:0]  Rd_channel = 3'd0;
  logic [11:0] Rd_data;
  logic        Busy;
  logic        Overrun;
  logic        Timeout_err;

  adc_scan_scheduler #(.PERIOD_W(16), .TIMEOUT(1023)) dut (
    .Clk(Clk), .Rst(Rst), .Scan_en(Scan_en), .Chan_mask(Chan_mask), .Period(Period),
    .En_convert(En_convert), .Adc_channel(Adc_channel), .Convert_done(Convert_done),
    .Adc_result(Adc_result), .Sample_valid(Sample_valid), .Sample_channel(Sample_channel),
    .Sample_data(Sample_data), .Scan_done(Scan_done), .Rd_channel(Rd_channel), .Rd_data(Rd_data),
    .Busy(Busy), .Overrun(Overrun), .Timeout_err(Timeout_err)
  );

  always #10 Clk = ~Clk;

  logic [11:0] vals [8] = '{12'h0A0, 12'h111, 12'h123, 12'h333, 12'h444, 12'hABC, 12'h666, 12'h777};
  logic [7:0]  dead = 8'd0;
  int          m_cnt = 0;
  logic [2:0]  m_ch = 3'd0;

  // ADC driver model: fixed conversion latency, channels flagged dead never answer.
  always @(negedge Clk) begin
    Convert_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        Convert_done = 1'b1;
        Adc_result   = vals[m_ch];
      end
    end
    if (En_convert === 1'b1 && !dead[Adc_channel]) begin
      m_cnt = LAT;
      m_ch  = Adc_channel;
    end
  end

  logic [14:0] obs_mem [256];
  int          obs_wr = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;

  always @(negedge Clk) begin
    if (Sample_valid === 1'b1) begin
      obs_mem[obs_wr] = {Sample_channel, Sample_data};
      obs_wr++;
    end
    if (En_convert === 1'b1) en_cnt++;
    if (Scan_done === 1'b1) done_cnt++;
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          obs_rd = 0;
  logic [14:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
  endtask

  task automatic push_exp(input int ch);
    exp_q.push_back({3'(ch), vals[ch]});
  endtask

  task automatic rd(input logic [2:0] ch, output logic [11:0] d);
    Rd_channel = ch;
    #1;
    d = Rd_data;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && Scan_done !== 1'b1; i++) @(negedge Clk);
    chk(tag, 32'(Scan_done), 32'd1);
  endtask

  task automatic wait_en(input logic [2:0] ch, input int budget, input string tag);
    for (int i = 0; i < budget && !(En_convert === 1'b1 && Adc_channel === ch); i++) @(negedge Clk);
    chk(tag, 32'(En_convert), 32'd1);
  endtask

  task automatic check_samples(input string tag);
    chk({tag, "_count"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      chk(tag, 32'(obs_mem[obs_rd]), 32'(exp_q.pop_front()));
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  initial begin
    logic [11:0] d;
    int          en0, d0;

    // Reset state
    tick(3);
    chk("rst_en_convert", 32'(En_convert), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_sample_valid", 32'(Sample_valid), 32'd0);
    chk("rst_scan_done", 32'(Scan_done), 32'd0);
    chk("rst_overrun", 32'(Overrun), 32'd0);
    chk("rst_timeout", 32'(Timeout_err), 32'd0);
    Rst = 1'b0;

    // Two-channel scan, long period
    Period = 16'd2000; Chan_mask = 8'b0010_0100; Scan_en = 1'b1;
    en0 = en_cnt;
    push_exp(2); push_exp(5);
    wait_done(2300, "t1_scan_done");
    chk("t1_busy_at_done", 32'(Busy), 32'd0);
    Scan_en = 1'b0;
    tick(5);
    chk("t1_busy_between", 32'(Busy), 32'd0);
    chk("t1_en_pulses", 32'(en_cnt - en0), 32'd2);
    chk("t1_overrun", 32'(Overrun), 32'd0);
    check_samples("t1_sample");
    rd(3'd5, d);
    chk("t1_rd5", 32'(d), 32'hABC);
    rd(3'd2, d);
    chk("t1_rd2", 32'(d), 32'h123);

    // Back-to-back full scans, then disable after the next scan begins
    do_reset();
    Period = 16'd0; Chan_mask = 8'hFF; Scan_en = 1'b1;
    for (int c = 0; c < 8; c++) push_exp(c);
    wait_done(400, "t2_scan_done");
    chk("t2_busy_at_done", 32'(Busy), 32'd0);
    tick(1);
    chk("t2_restart_busy", 32'(Busy), 32'd1);
    Scan_en = 1'b0;
    push_exp(0);
    wait_done(100, "t2_stop_done");
    tick(2);
    check_samples("t2_sample");

    // Period shorter than a scan
    do_reset();
    Period = 16'd100; Chan_mask = 8'hFF; Scan_en = 1'b1;
    for (int c = 0; c < 8; c++) push_exp(c);
    wait_done(500, "t3_scan_done");
    Scan_en = 1'b0;
    chk("t3_overrun", 32'(Overrun), 32'd1);
    tick(2);
    check_samples("t3_sample");

    // Channel 3 never answers
    do_reset();
    dead = 8'h08;
    Period = 16'd10; Chan_mask = 8'h08; Scan_en = 1'b1;
    wait_en(3'd3, 100, "t4_start");
    Scan_en = 1'b0;
    tick(1023);
    chk("t4_timeout_early", 32'(Timeout_err), 32'd0);
    chk("t4_done_early", 32'(Scan_done), 32'd0);
    tick(1);
    chk("t4_timeout", 32'(Timeout_err), 32'd1);
    chk("t4_scan_done", 32'(Scan_done), 32'd1);
    tick(2);
    check_samples("t4_sample");
    rd(3'd3, d);
    chk("t4_rd3", 32'(d), 32'd0);
    dead = 8'd0;

    // Scan_en dropped during the ch1 conversion
    Period = 16'd10; Chan_mask = 8'h0F; Scan_en = 1'b1;
    en0 = en_cnt; d0 = done_cnt;
    push_exp(0); push_exp(1);
    wait_en(3'd1, 200, "t5_ch1_start");
    tick(3);
    Scan_en = 1'b0;
    wait_done(100, "t5_scan_done");
    tick(50);
    chk("t5_en_pulses", 32'(en_cnt - en0), 32'd2);
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_samples("t5_sample");

    // Reset while waiting for a conversion
    Period = 16'd10; Chan_mask = 8'h01; Scan_en = 1'b1;
    wait_en(3'd0, 100, "t6_start");
    Scan_en = 1'b0;
    tick(3);
    chk("t6_timeout_pre", 32'(Timeout_err), 32'd1);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    chk("t6_en_convert", 32'(En_convert), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);
    chk("t6_timeout", 32'(Timeout_err), 32'd0);
    chk("t6_overrun", 32'(Overrun), 32'd0);
    rd(3'd1, d);
    chk("t6_rd1", 32'(d), 32'd0);
    rd(3'd0, d);
    chk("t6_rd0", 32'(d), 32'd0);
    tick(30);
    chk("t6_busy_late", 32'(Busy), 32'd0);
    check_samples("t6_sample");

    // Empty mask never starts a scan
    en0 = en_cnt;
    Period = 16'd0; Chan_mask = 8'h00; Scan_en = 1'b1;
    tick(5000);
    chk("t7_en_pulses", 32'(en_cnt - en0), 32'd0);
    chk("t7_busy", 32'(Busy), 32'd0);
    chk("t7_overrun", 32'(Overrun), 32'd0);
    Scan_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Autonomous scan controller that sequences the adc_18s022 serial ADC driver.
- On each sample-period tick it runs one conversion per enabled channel, in ascending order 0..7.
- Latches each 12-bit result into a per-channel result register file and streams each sample out with a valid pulse.
- Sits between the adc_18s022 instance and the measurement/display logic; it is the only block that drives the driver's En_convert/Adc_channel.

Parameters:
- PERIOD_W, 16: width of the Period input and the tick counter.
- TIMEOUT, 1023: max Clk cycles to wait for Convert_done per conversion (one conversion ≈ 420 cycles at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz
- Rst  in  1  synchronous, active-high reset
- Scan_en  in  1  level; enables periodic scanning
- Chan_mask  in  8  bit n = 1 enables channel n
- Period  in  PERIOD_W  tick interval in Clk cycles; 0 = back-to-back scans
- En_convert  out  1  one-cycle start pulse to adc_18s022
- Adc_channel  out  3  channel address to adc_18s022
- Convert_done  in  1  end-of-conversion pulse from adc_18s022
- Adc_result  in  12  conversion result from adc_18s022, valid with Convert_done
- Sample_valid  out  1  one-cycle pulse: new sample on Sample_channel/Sample_data
- Sample_channel  out  3  channel of current sample
- Sample_data  out  12  current sample value
- Scan_done  out  1  one-cycle pulse after the last enabled channel of a scan completes
- Rd_channel  in  3  result register file read address
- Rd_data  out  12  last stored result for Rd_channel (combinational read)
- Busy  out  1  high from scan start until the cycle Scan_done pulses
- Overrun  out  1  sticky: a tick arrived while Busy
- Timeout_err  out  1  sticky: a conversion exceeded TIMEOUT

Behaviour:
- Reset (Rst high at a Clk edge):
  - All outputs and registers go to 0. This includes the result file, Overrun, Timeout_err and the tick counter.
  - State goes to IDLE. En_convert is 0 in the same cycle.
  - Reset mid-conversion simply abandons it; a late Convert_done after reset is ignored (state is IDLE).
- Tick counter:
  - Free-running while Scan_en = 1; counts 0..Period-1 and pulses tick when it wraps.
  - Held at 0 while Scan_en = 0.
  - Period = 0: tick is constantly true, so a new scan starts the cycle after Scan_done.
- State machine: IDLE, SELECT, START, WAIT_DONE, STORE.
  - IDLE: on tick with Scan_en = 1 and Chan_mask != 0, latch the mask into scan_mask, set Busy = 1, go to SELECT. A tick with mask = 0 is ignored and does not set Overrun.
  - SELECT: pick the lowest set bit of scan_mask, load it into Adc_channel, clear that bit, go to START.
  - START: En_convert = 1 for exactly this cycle; go to WAIT_DONE. Adc_channel stays stable from SELECT until STORE exits.
  - WAIT_DONE: wait for Convert_done.
    - If Convert_done arrives, capture Adc_result and go to STORE.
    - The timeout counter resets on entry. If it reaches TIMEOUT without Convert_done: set Timeout_err, write no result and pulse no Sample_valid, then continue as if STORE finished.
  - STORE:
    - Write result[Adc_channel] and pulse Sample_valid with Sample_channel/Sample_data.
    - If scan_mask != 0 and Scan_en = 1, go to SELECT.
    - Otherwise pulse Scan_done, drop Busy, go to IDLE.
- Latency per channel: 2 cycles (SELECT + START) plus the driver's conversion time plus 1 cycle (STORE).
- Scan_en deasserted mid-scan: the conversion in flight completes and is stored, then the scan ends with a Scan_done pulse.
- Chan_mask changes mid-scan are ignored until the next scan.
- Tick while Busy: the tick is dropped and Overrun is set.
- Convert_done outside WAIT_DONE is ignored.
- Sample_channel/Sample_data hold their last values between pulses.

Test Plan:
- Period = 2000, Chan_mask = 8'b0010_0100, model returns 12'h123 for ch2 and 12'hABC for ch5 → ch2 sampled before ch5, each conversion has exactly one En_convert pulse, Scan_done after ch5, Rd_channel = 5 reads 12'hABC, Busy low between scans, Overrun = 0.
- Chan_mask = 8'hFF, Period = 0 → channels 0..7 sampled in order and the next scan starts the cycle after Scan_done. Period = 100 (shorter than a scan) → Overrun = 1.
- Model never returns Convert_done for ch3, mask = 8'h08 → Timeout_err = 1 after 1023 cycles, no Sample_valid, Scan_done pulses, result[3] stays 0.
- Chan_mask = 8'h0F, clear Scan_en during the ch1 conversion → ch1 stored, no ch2/ch3 conversion, Scan_done pulses once.
- Assert Rst during WAIT_DONE → next cycle En_convert = 0, Busy = 0, all flags and results 0. A subsequent Convert_done produces no Sample_valid.
- Chan_mask = 0 with Scan_en = 1 for 5000 cycles → no En_convert, Busy = 0, Overrun = 0.
